hy_stream_loader: RTL and testbench

//   Front end of the pre-processing stage. Collects a channel frame from a

---
 rtl/hy_stream_loader.sv | 210 +++++++++++++++++++++
 tb/tb_hy_stream_loader.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/hy_stream_loader.sv
// -----------------------------------------------------------------------------
// hy_stream_loader
//
// Purpose:
//   Front end of the pre-processing stage. Collects one channel frame from a
//   serial element stream into sixteen packed Hermitian-row vectors H1..H16
//   and the received vector y_vec. When the last element lands, it pulses
//   en_out once to start the Gram / matched-filter stage. It then refuses
//   new input for HOLD_CYCLES more cycles so the vectors stay frozen while
//   that stage computes.
//
//   Stream order per frame: H1[0..D-1], H2[0..D-1], ..., H16[0..D-1],
//   y[0..D-1]. That is 17*DIMENSION accepted beats per frame.
//
// Ports:
//   clk        in   1                 system clock, rising edge
//   rst        in   1                 asynchronous reset, active-high
//   in_data    in   WIDTH             signed element, qualified by in_valid
//   in_valid   in   1                 source presents an element
//   in_ready   out  1                 loader accepts (beat = in_valid & in_ready)
//   flush      in   1                 abort the current frame, restart at H1[0]
//   H1..H16    out  DIMENSION*WIDTH   packed vectors, element i at [i*WIDTH +: WIDTH]
//   y_vec      out  DIMENSION*WIDTH   packed received vector, same packing
//   en_out     out  1                 one-cycle pulse: frame complete, outputs valid
//   busy       out  1                 high while firing / holding
// -----------------------------------------------------------------------------
module hy_stream_loader #(
  parameter int DIMENSION   = 256,
  parameter int WIDTH       = 8,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       flush,
  output logic [DIMENSION*WIDTH-1:0] H1,
  output logic [DIMENSION*WIDTH-1:0] H2,
  output logic [DIMENSION*WIDTH-1:0] H3,
  output logic [DIMENSION*WIDTH-1:0] H4,
  output logic [DIMENSION*WIDTH-1:0] H5,
  output logic [DIMENSION*WIDTH-1:0] H6,
  output logic [DIMENSION*WIDTH-1:0] H7,
  output logic [DIMENSION*WIDTH-1:0] H8,
  output logic [DIMENSION*WIDTH-1:0] H9,
  output logic [DIMENSION*WIDTH-1:0] H10,
  output logic [DIMENSION*WIDTH-1:0] H11,
  output logic [DIMENSION*WIDTH-1:0] H12,
  output logic [DIMENSION*WIDTH-1:0] H13,
  output logic [DIMENSION*WIDTH-1:0] H14,
  output logic [DIMENSION*WIDTH-1:0] H15,
  output logic [DIMENSION*WIDTH-1:0] H16,
  output logic [DIMENSION*WIDTH-1:0] y_vec,
  output logic                       en_out,
  output logic                       busy
);

  localparam int VW      = DIMENSION * WIDTH;
  localparam int NUM_VEC = 17;                  // H1..H16 plus y
  // Keep counters at least one bit wide so degenerate parameters still build.
  localparam int EW = (DIMENSION   > 1) ? $clog2(DIMENSION)   : 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [EW-1:0] LAST_ELEM = EW'(DIMENSION - 1);
  localparam logic [4:0]    LAST_VEC  = 5'd16;  // vec_cnt 16 selects y
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_FIRE = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t        r_state;
  logic [EW-1:0] r_elem_cnt;
  logic [4:0]    r_vec_cnt;
  logic [HW-1:0] r_hold_cnt;
  logic          r_in_ready;
  logic          r_en_out;
  logic          r_busy;

  logic          w_beat;
  logic          w_last_elem;
  logic          w_last_vec;
  logic [31:0]   w_base;

  // r_in_ready is high only in LOAD, so a beat can only occur while loading.
  assign w_beat      = in_valid & r_in_ready;
  assign w_last_elem = (r_elem_cnt == LAST_ELEM);
  assign w_last_vec  = (r_vec_cnt == LAST_VEC);
  assign w_base      = 32'(r_elem_cnt) * WIDTH;

  // ---------------------------------------------------------------------------
  // Control FSM with registered handshake / status outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_LOAD;
      r_elem_cnt <= '0;
      r_vec_cnt  <= '0;
      r_hold_cnt <= '0;
      r_in_ready <= 1'b1;
      r_en_out   <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (flush) begin
            // Flush beats everything, including the final beat of a frame.
            // A beat in this cycle is still captured by the storage below.
            r_elem_cnt <= '0;
            r_vec_cnt  <= '0;
          end else if (w_beat) begin
            if (w_last_elem) begin
              r_elem_cnt <= '0;
              if (w_last_vec) begin
                r_vec_cnt  <= '0;
                r_state    <= S_FIRE;
                r_in_ready <= 1'b0;
                r_en_out   <= 1'b1;
                r_busy     <= 1'b1;
              end else begin
                r_vec_cnt <= r_vec_cnt + 5'd1;
              end
            end else begin
              r_elem_cnt <= r_elem_cnt + EW'(1);
            end
          end
        end

        S_FIRE: begin
          // en_out is high for exactly this one cycle.
          r_en_out   <= 1'b0;
          r_hold_cnt <= HOLD_INIT;
          r_state    <= S_HOLD;
        end

        S_HOLD: begin
          if (r_hold_cnt == '0) begin
            r_state    <= S_LOAD;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b0;
          end else begin
            r_hold_cnt <= r_hold_cnt - HW'(1);
          end
        end

        default: begin
          r_state    <= S_LOAD;
          r_elem_cnt <= '0;
          r_vec_cnt  <= '0;
          r_hold_cnt <= '0;
          r_in_ready <= 1'b1;
          r_en_out   <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Vector storage: one register per vector, one element written per beat.
  // Untouched elements keep the previous frame's contents.
  // ---------------------------------------------------------------------------
  logic [VW-1:0] w_vec [0:NUM_VEC-1];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_VEC; gi++) begin : g_vec
      logic [VW-1:0] r_data;
      logic          w_we;

      assign w_we = w_beat && (r_vec_cnt == 5'(gi));

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_data <= '0;
        end else if (w_we) begin
          r_data[w_base +: WIDTH] <= in_data;
        end
      end

      assign w_vec[gi] = r_data;
    end
  endgenerate

  assign H1    = w_vec[0];
  assign H2    = w_vec[1];
  assign H3    = w_vec[2];
  assign H4    = w_vec[3];
  assign H5    = w_vec[4];
  assign H6    = w_vec[5];
  assign H7    = w_vec[6];
  assign H8    = w_vec[7];
  assign H9    = w_vec[8];
  assign H10   = w_vec[9];
  assign H11   = w_vec[10];
  assign H12   = w_vec[11];
  assign H13   = w_vec[12];
  assign H14   = w_vec[13];
  assign H15   = w_vec[14];
  assign H16   = w_vec[15];
  assign y_vec = w_vec[16];

  assign in_ready = r_in_ready;
  assign en_out   = r_en_out;
  assign busy     = r_busy;

endmodule

// File: tb/tb_hy_stream_loader.sv
// -----------------------------------------------------------------------------
// tb_hy_stream_loader
//
// Purpose:
//   Self-checking bench for hy_stream_loader at DIMENSION=4, WIDTH=8,
//   HOLD_CYCLES=4. A frame-level reference model predicts the outputs. It
//   tracks a beat position 0..67 and a lockout countdown, and stores
//   elements at [pos/D][pos%D]. The bench compares every output after
//   every clock edge.
// -----------------------------------------------------------------------------
module tb_hy_stream_loader;

  localparam int DIM  = 4;
  localparam int W    = 8;
  localparam int HOLD = 4;
  localparam int NV   = 17;
  localparam int FB   = NV * DIM;   // beats per frame

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  in_data;
  logic          in_valid;
  logic          in_ready;
  logic          flush;
  logic [31:0]   dut_h [0:15];
  logic [31:0]   y_vec;
  logic          en_out;
  logic          busy;

  always #5 clk = ~clk;

  hy_stream_loader #(
    .DIMENSION  (DIM),
    .WIDTH      (W),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .in_data (in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .flush   (flush),
    .H1      (dut_h[0]),
    .H2      (dut_h[1]),
    .H3      (dut_h[2]),
    .H4      (dut_h[3]),
    .H5      (dut_h[4]),
    .H6      (dut_h[5]),
    .H7      (dut_h[6]),
    .H8      (dut_h[7]),
    .H9      (dut_h[8]),
    .H10     (dut_h[9]),
    .H11     (dut_h[10]),
    .H12     (dut_h[11]),
    .H13     (dut_h[12]),
    .H14     (dut_h[13]),
    .H15     (dut_h[14]),
    .H16     (dut_h[15]),
    .y_vec   (y_vec),
    .en_out  (en_out),
    .busy    (busy)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  logic [7:0] m_vec [0:NV-1][0:DIM-1];
  int         m_pos;    // next beat position within the frame
  int         m_lock;   // cycles left with input refused (FIRE + HOLD)
  int         en_seen;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_vec(input int v);
    return {m_vec[v][3], m_vec[v][2], m_vec[v][1], m_vec[v][0]};
  endfunction

  function automatic logic [31:0] dut_vec(input int v);
    return (v < 16) ? dut_h[v] : y_vec;
  endfunction

  task automatic model_reset();
    for (int v = 0; v < NV; v++)
      for (int e = 0; e < DIM; e++)
        m_vec[v][e] = 8'h00;
    m_pos  = 0;
    m_lock = 0;
  endtask

  task automatic check_all(input string tag);
    chk($sformatf("%s_in_ready", tag), 32'(in_ready), 32'(m_lock == 0));
    chk($sformatf("%s_en_out", tag),   32'(en_out),   32'(m_lock == HOLD + 1));
    chk($sformatf("%s_busy", tag),     32'(busy),     32'(m_lock > 0));
    for (int v = 0; v < NV; v++)
      chk($sformatf("%s_vec%0d", tag, v), dut_vec(v), model_vec(v));
  endtask

  // Drive one cycle of inputs, advance the model across the edge, check.
  task automatic cycle(input logic v, input logic [7:0] d, input logic f);
    logic beat;
    in_valid = v;
    in_data  = d;
    flush    = f;
    beat     = v && (m_lock == 0);
    @(posedge clk);
    #1;
    if (m_lock > 0) begin
      m_lock--;
    end else begin
      if (beat) m_vec[m_pos / DIM][m_pos % DIM] = d;
      if (f) begin
        m_pos = 0;
      end else if (beat) begin
        if (m_pos == FB - 1) begin
          m_pos  = 0;
          m_lock = HOLD + 1;
        end else begin
          m_pos++;
        end
      end
    end
    if (en_out) en_seen++;
    check_all("cyc");
  endtask

  initial begin
    int nready;
    int k;
    int guard;
    logic v;

    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    flush    = 1'b0;
    en_seen  = 0;
    model_reset();
    #12;
    check_all("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // T1: asynchronous reset in the middle of a frame.
    for (int i = 0; i < 10; i++) cycle(1'b1, 8'($urandom), 1'b0);
    in_valid = 1'b0;
    #3 rst = 1'b1;
    #1;
    model_reset();
    check_all("t1_rst");
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    check_all("t1_post");
    $display("T1 reset mid-stream done, checks=%0d failures=%0d", checks, failures);

    // T2: gapless frame, beat k carries k.
    en_seen = 0;
    for (int i = 0; i < FB; i++) cycle(1'b1, 8'(i), 1'b0);
    chk("t2_h1",  dut_h[0],  32'h03020100);
    chk("t2_h16", dut_h[15], 32'h3F3E3D3C);
    chk("t2_y",   y_vec,     32'h43424140);
    chk("t2_en",  32'(en_out), 32'd1);
    $display("T2 full frame done, checks=%0d failures=%0d", checks, failures);

    // T3: backpressure while firing/holding.
    nready = 0;
    for (int i = 0; i < HOLD + 1; i++) begin
      if (!in_ready) nready++;
      cycle(1'b1, 8'hEE, 1'b0);
    end
    chk("t3_lowcycles", 32'(nready), 32'(HOLD + 1));
    chk("t3_ready_back", 32'(in_ready), 32'd1);
    chk("t3_en_count", 32'(en_seen), 32'd1);
    cycle(1'b1, 8'h55, 1'b0);
    chk("t3_first_beat", 32'(dut_h[0][7:0]), 32'h55);
    cycle(1'b0, 8'h00, 1'b1);   // flush without a beat, back to H1[0]
    $display("T3 backpressure done, checks=%0d failures=%0d", checks, failures);

    // T4: random bubbles, negative data 0x80..0xC3.
    en_seen = 0;
    k = 0;
    guard = 0;
    while (k < FB && guard < 2000) begin
      v = 1'($urandom_range(0, 1));
      cycle(v, 8'h80 + 8'(k), 1'b0);
      if (v) k++;
      guard++;
    end
    chk("t4_beats", 32'(k), 32'(FB));
    chk("t4_h1_0", 32'(dut_h[0][7:0]), 32'h80);
    chk("t4_y", y_vec, 32'hC3C2C1C0);
    for (int i = 0; i < HOLD + 2; i++) cycle(1'b0, 8'h00, 1'b0);
    chk("t4_en_count", 32'(en_seen), 32'd1);
    $display("T4 bubbles done, checks=%0d failures=%0d", checks, failures);

    // T5: flush on beat 30, then a complete new frame.
    for (int i = 0; i < 30; i++) cycle(1'b1, 8'($urandom), 1'b0);
    cycle(1'b1, 8'($urandom), 1'b1);
    en_seen = 0;
    for (int i = 0; i < FB; i++) begin
      cycle(1'b1, 8'h10 + 8'(i), 1'b0);
      if (i == FB - 2) chk("t5_no_early_en", 32'(en_seen), 32'd0);
    end
    chk("t5_en_count", 32'(en_seen), 32'd1);
    chk("t5_h2", dut_h[1], 32'h17161514);
    for (int i = 0; i < HOLD + 2; i++) cycle(1'b0, 8'h00, 1'b0);
    $display("T5 flush mid-frame done, checks=%0d failures=%0d", checks, failures);

    // T6: flush on the final beat.
    en_seen = 0;
    for (int i = 0; i < FB - 1; i++) cycle(1'b1, 8'h20 + 8'(i), 1'b0);
    cycle(1'b1, 8'h63, 1'b1);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_y3", 32'(y_vec[31:24]), 32'h63);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b0);
    chk("t6_en_count", 32'(en_seen), 32'd0);
    cycle(1'b1, 8'hA5, 1'b0);
    chk("t6_restart", 32'(dut_h[0][7:0]), 32'hA5);
    $display("T6 flush on final beat done, checks=%0d failures=%0d", checks, failures);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
